// File: rtl/wide_add_seq.sv
// wide_add_seq: W=N*K-bit add/subtract built from one shared N-bit ripple adder, one slice per clock
module myadd #(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end
  assign cout = c[N];
endmodule

module wide_add_seq #(
  parameter int N = 8,
  parameter int K = 4,
  localparam int W = N * K
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q;
  logic [IW-1:0]  idx_q;
  logic           cf_q, busy_q, done_q, cout_q, ovf_q;
  logic [W-1:0]   a_q, b_q, shadow_q, shadow_d, result_q;
  logic [N-1:0]   s;
  logic           co, last;
  myadd #(.N(N)) u_add (
    .x   (a_q[idx_q*N +: N]),
    .y   (b_q[idx_q*N +: N]),
    .cin (cf_q),
    .s   (s),
    .cout(co)
  );
  assign last = idx_q == IW'(K - 1);
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[idx_q*N +: N] = s;
  end
  // b_q holds the already-inverted operand for subtraction; cf seeds the +1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cf_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      shadow_q <= '0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            cf_q    <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          shadow_q <= shadow_d;
          cf_q     <= co;
          idx_q    <= idx_q + IW'(1);
          if (last) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= shadow_d;
            cout_q   <= co;
            ovf_q    <= (a_q[W-1] == b_q[W-1]) && (s[N-1] != a_q[W-1]);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_wide_add_seq.sv
// tb_wide_add_seq: randomized and directed checks of wide_add_seq against a plain-arithmetic model
module tb_wide_add_seq;
  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;
  logic         clk = 0, rst = 1, start = 0, sub = 0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] result;
  logic [W-1:0] last_res = '0;
  int n_cmp = 0, n_bad = 0;
  wide_add_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] t;
    if (s) begin
      r = x - y;
      c = x >= y;
      o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      t = {1'b0, x} + {1'b0, y};
      r = t[W-1:0];
      c = t[W];
      o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
  endfunction
  // Call at a negedge where the DUT can accept start (IDLE or DONE cycle); returns at the done-cycle negedge.
  task automatic do_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    logic [W-1:0] er;
    logic ec, eo;
    int lat, nb;
    model(s, x, y, er, ec, eo);
    start = 1; sub = s; a = x; b = y;
    @(negedge clk);
    start = 0; sub = $urandom; a = $urandom; b = $urandom;
    lat = 1; nb = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      check("hold", result, last_res);
      @(negedge clk);
      lat++;
      start = poke && lat == 2;
      if (start) begin a = $urandom; b = $urandom; sub = $urandom; end
    end
    start = 0;
    check("latency", lat, K + 1);
    check("busy_cycles", nb, K);
    check("done", done, 1);
    check("busy_in_done", busy, 0);
    check("result", result, er);
    check("cout", cout, ec);
    check("ovf", ovf, eo);
    last_res = er;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 0;
    @(negedge clk);
    do_op(0, 32'h0000_00FF, 32'h0000_0001, 0);
    @(negedge clk);
    do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    @(negedge clk);
    do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    @(negedge clk);
    do_op(1, 32'd5, 32'd7, 0);
    @(negedge clk);
    do_op(1, 32'h8000_0000, 32'h0000_0001, 0);
    @(negedge clk);
    do_op(0, 32'h1234_5678, 32'h1111_1111, 1);
    do_op(1, 32'h0000_0010, 32'h0000_0020, 0);
    do_op(0, 32'h8000_0000, 32'h8000_0000, 0);
    @(negedge clk);
    start = 1; sub = 0; a = 32'hDEAD_BEEF; b = 32'h0101_0101;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
    check("abort_ovf", ovf, 0);
    last_res = '0;
    repeat (K + 2) begin
      @(negedge clk);
      check("abort_no_done", done, 0);
    end
    do_op(0, 32'h0F0F_0F0F, 32'hF0F0_F0F1, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1, 0) == 0) @(negedge clk);
      do_op($urandom_range(1, 0), $urandom, (i % 8 == 0) ? 32'hFFFF_FFFF : $urandom, $urandom_range(3, 0) == 0);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
